// File: rtl/cla_seq_adder.sv
// Multi-cycle adder: one 4-bit carry-lookahead nibble per clock, LS nibble first.
// Optional subtract mode (port `sub`) is enabled by defining CLA_SUB_EN.
module cla_seq_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef CLA_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero,
    output logic             busy,
    output logic             done
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic           c;
    logic [IW-1:0]  idx;

    logic           accept;
    logic           last;
    logic [3:0]     a_nib;
    logic [3:0]     b_nib;
    logic [3:0]     g;
    logic [3:0]     p;
    logic [3:0]     cl;
    logic [3:0]     s_nib;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state plus the lookahead datapath for the current nibble
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last     = (idx == IW'(NIB - 1));
        a_nib    = 4'(a_q >> {idx, 2'b00});
        b_nib    = 4'(b_q >> {idx, 2'b00});
        g        = a_nib & b_nib;
        p        = a_nib ^ b_nib;

        cl[0] = g[0] | (p[0] & c);
        cl[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        cl[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        cl[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c);
        s_nib = p ^ {cl[2:0], c};

        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, per-nibble accumulation and registered flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            c    <= 1'b0;
            idx  <= '0;
            Sum  <= '0;
            Cout <= 1'b0;
            Ovf  <= 1'b0;
            Zero <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nx == RUN);
            done <= (state == DONE);

            if (accept) begin
                a_q <= A;
                idx <= '0;
`ifdef CLA_SUB_EN
                b_q <= sub ? ~B : B;
                c   <= sub ? 1'b1 : Cin;
`else
                b_q <= B;
                c   <= Cin;
`endif
            end else if (state == RUN) begin
                c <= cl[3];
                for (int unsigned k = 0; k < NIB; k++) begin
                    if (idx == IW'(k)) begin
                        Sum[4*k +: 4] <= s_nib;
                    end
                end
                if (last) begin
                    Cout <= cl[3];
                    Ovf  <= cl[3] ^ cl[2];
                end else begin
                    idx <= idx + IW'(1);
                end
            end

            // Sum is complete once RUN has finished
            if (state == DONE) begin
                Zero <= (Sum == '0);
            end
        end
    end

endmodule
